// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the front of the 5-stage pipeline.
// Handles load-use bubbles, branch mispredict flushes, multi-cycle FP holds
// and data-cache miss freezes. Optional performance counters are built when
// HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned FP_LAT = 4
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W  = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRd,
    input  logic             ex_mispredict,
    input  logic             ex_fp_start,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
`endif
    output logic             busy
);

    localparam int unsigned FP_CNT_W = 4;
    localparam bit          FP_EN    = (FP_LAT > 1);
    // Remaining FP_BUSY cycles after the first one; the start cycle itself is in RUN.
    localparam logic [FP_CNT_W-1:0] FP_INIT = FP_EN ? FP_CNT_W'(FP_LAT - 2) : '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FP_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [FP_CNT_W-1:0] fp_cnt_q, fp_cnt_d;
    logic                lu;

    // Load-use hazard between the EX-stage load and the decode sources.
    always_comb begin
        lu = ex_MemRd && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // State and FP countdown register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            fp_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            fp_cnt_q <= fp_cnt_d;
        end
    end

    // Next-state and combinational stall/flush controls.
    always_comb begin
        state_d     = state_q;
        fp_cnt_d    = fp_cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        busy        = (state_q != RUN);

        unique case (state_q)
            RUN: begin
                if (dcache_miss) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (ex_mispredict) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_fp_start && FP_EN) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                    fp_cnt_d   = FP_INIT;
                    state_d    = FP_BUSY;
                end else if (lu) begin
                    // The bubble clears ex_MemRd next cycle, ending the hazard.
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            FP_BUSY: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_stall = 1'b1;
                if (dcache_miss) begin
                    // Countdown is frozen and resumes once the refill completes.
                    exmem_stall = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (fp_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fp_cnt_d = fp_cnt_q - FP_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
                if (dcache_ready) begin
                    state_d = (fp_cnt_q != '0) ? FP_BUSY : RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

    // Saturating stall/flush cycle counters.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (pc_stall && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + CNT_W'(1);
        end
        if (idex_flush && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios with a per-cycle expected-output queue.
// Counter checks are built when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_MemRd, ex_mispredict, ex_fp_start;
    logic       dcache_miss, dcache_ready;
    logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic       ifid_flush, idex_flush, busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    pipe_hazard_ctrl #(.FP_LAT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_rd         (ex_rd),
        .ex_MemRd      (ex_MemRd),
        .ex_mispredict (ex_mispredict),
        .ex_fp_start   (ex_fp_start),
        .dcache_miss   (dcache_miss),
        .dcache_ready  (dcache_ready),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .idex_stall    (idex_stall),
        .exmem_stall   (exmem_stall),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
`ifdef HAZ_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Output vector: {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, busy}
    localparam logic [6:0] O_IDLE  = 7'b000_0_00_0;
    localparam logic [6:0] O_LU    = 7'b110_0_01_0;
    localparam logic [6:0] O_MISP  = 7'b000_0_11_0;
    localparam logic [6:0] O_FPS   = 7'b111_0_00_0;
    localparam logic [6:0] O_FPB   = 7'b111_0_00_1;
    localparam logic [6:0] O_MISS  = 7'b111_1_00_0;
    localparam logic [6:0] O_MW    = 7'b111_1_00_1;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [6:0]  exp_q[$];
    string       tag_q[$];

    function automatic logic [6:0] outs();
        return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_MemRd = 0;
        ex_mispredict = 0; ex_fp_start = 0; dcache_miss = 0; dcache_ready = 0;
    endtask

    // Drive one cycle of stimulus (already set by caller via clr + overrides) and queue its expectation.
    task automatic push(input string tag, input logic [6:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic cyc_idle(input string tag, input logic [6:0] exp);
        @(posedge clk); #1;
        clr();
        push(tag, exp);
    endtask

    // Compare the queued expectation mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk(tag_q.pop_front(), 32'(outs()), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        clr();
        rst = 1'b0;
        cyc_idle("reset0", O_IDLE);
        cyc_idle("reset1", O_IDLE);
        @(posedge clk); #1 rst = 1'b1;
        cyc_idle("post_reset", O_IDLE);

        // Load-use via rs1: one bubble, then clear.
        @(posedge clk); #1; clr(); ex_MemRd = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        push("lu_rs1", O_LU);
        cyc_idle("lu_rs1_after", O_IDLE);
        // Load-use via rs2.
        @(posedge clk); #1; clr(); ex_MemRd = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
        push("lu_rs2", O_LU);
        // Match on rs2 but not actually read.
        @(posedge clk); #1; clr(); ex_MemRd = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
        push("lu_unused", O_IDLE);
        // x0 destination never stalls.
        @(posedge clk); #1; clr(); ex_MemRd = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        push("lu_x0", O_IDLE);

        // Mispredict beats a concurrent load-use.
        @(posedge clk); #1; clr(); ex_mispredict = 1; ex_MemRd = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        push("misp_lu", O_MISP);
        cyc_idle("misp_after", O_IDLE);

        // FP op: 4 cycles of pc_stall, busy for the last 3.
        @(posedge clk); #1; clr(); ex_fp_start = 1;
        push("fp_start", O_FPS);
        for (int i = 0; i < 3; i++) cyc_idle($sformatf("fp_busy%0d", i), O_FPB);
        cyc_idle("fp_done", O_IDLE);

        // Miss during FP_BUSY with one FP cycle left, ready 5 cycles later.
        @(posedge clk); #1; clr(); ex_fp_start = 1;
        push("fpm_start", O_FPS);
        cyc_idle("fpm_busy", O_FPB);
        @(posedge clk); #1; clr(); dcache_miss = 1;
        push("fpm_miss", O_MW);
        for (int i = 0; i < 4; i++) cyc_idle($sformatf("fpm_wait%0d", i), O_MW);
        @(posedge clk); #1; clr(); dcache_ready = 1;
        push("fpm_ready", O_MW);
        cyc_idle("fpm_resume0", O_FPB);
        cyc_idle("fpm_resume1", O_FPB);
        cyc_idle("fpm_done", O_IDLE);

        // Miss and ready together in RUN count as a miss.
        @(posedge clk); #1; clr(); dcache_miss = 1; dcache_ready = 1;
        push("miss_rdy", O_MISS);
        @(posedge clk); #1; clr(); dcache_ready = 1;
        push("miss_rdy_wait", O_MW);
        cyc_idle("miss_rdy_done", O_IDLE);

        // Mispredict and load-use ignored while FP_BUSY.
        @(posedge clk); #1; clr(); ex_fp_start = 1;
        push("fpi_start", O_FPS);
        @(posedge clk); #1; clr(); ex_mispredict = 1;
        push("fpi_misp", O_FPB);
        @(posedge clk); #1; clr(); ex_MemRd = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        push("fpi_lu", O_FPB);
        cyc_idle("fpi_busy", O_FPB);
        cyc_idle("fpi_done", O_IDLE);

        // Asynchronous reset mid MEM_WAIT.
        @(posedge clk); #1; clr(); dcache_miss = 1;
        push("ar_miss", O_MISS);
        cyc_idle("ar_wait", O_MW);
        @(negedge clk); #2 rst = 1'b0;
        #1 chk("async_rst", 32'(outs()), 32'(O_IDLE));
        @(posedge clk); #1 rst = 1'b1;
        cyc_idle("ar_after", O_IDLE);

`ifdef HAZ_PERF_CNT_EN
        // Mispredict then FP op back to back.
        @(posedge clk); #1; clr(); ex_mispredict = 1;
        push("pc_misp", O_MISP);
        @(posedge clk); #1; clr(); ex_fp_start = 1;
        push("pc_fp", O_FPS);
        for (int i = 0; i < 3; i++) cyc_idle($sformatf("pc_busy%0d", i), O_FPB);
        cyc_idle("pc_done", O_IDLE);
        @(negedge clk); #1;
        chk("perf_flush", perf_flush_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd4);
`endif

        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall/flush sequencer for the 5-stage RV32F pipeline. It watches decode-stage source registers and execute-stage control state. It drives the hold and bubble controls of the PC, IF/ID and ID/EX registers for four cases: load-use hazards, branch mispredicts, multi-cycle FPU operations and data-cache misses. It sits beside the ID/EX register and is the only block allowed to freeze or flush the front of the pipeline.

## Interface
Parameters:
- FP_LAT, 4: cycles a multi-cycle FP op occupies EX (1..16); 1 disables FP stalling.
- CNT_W, 32: width of performance counters (only with HAZ_PERF_CNT_EN).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- id_rs1, id_rs2  in  5 each  decode-stage source register indices.
- id_use_rs1, id_use_rs2  in  1 each  decode instruction actually reads rs1/rs2.
- ex_rd  in  5  execute-stage destination.
- ex_MemRd  in  1  execute-stage instruction is a load.
- ex_mispredict  in  1  branch/jump resolved in EX disagrees with prediction.
- ex_fp_start  in  1  multi-cycle FP op enters EX this cycle.
- dcache_miss  in  1  data-cache miss on the MEM-stage access.
- dcache_ready  in  1  refill complete; MEM data valid this cycle.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold register contents.
- ifid_flush, idex_flush  out  1 each  load NOP/zero controls (bubble).
- busy  out  1  state != RUN.
- perf_stall_cnt, perf_flush_cnt  out  CNT_W each  (HAZ_PERF_CNT_EN only).

## Operation
- States: RUN, FP_BUSY, MEM_WAIT. Registered state plus 4-bit down-counter fp_cnt. All outputs are combinational from state and inputs.
- Load-use hazard: `lu = ex_MemRd & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- RUN, evaluated in priority order:
  1. dcache_miss: assert all four stalls, go MEM_WAIT.
  2. ex_mispredict: assert ifid_flush and idex_flush, no stalls, stay RUN.
  3. ex_fp_start and FP_LAT > 1: assert pc_stall, ifid_stall, idex_stall. Set fp_cnt = FP_LAT-2 and go FP_BUSY. If FP_LAT == 2, the FP_BUSY stay is one cycle.
  4. lu: assert pc_stall, ifid_stall, idex_flush for one cycle, stay RUN. The bubble clears ex_MemRd next cycle, so the hazard self-terminates.
  5. Otherwise all outputs 0.
- FP_BUSY:
  - pc_stall, ifid_stall, idex_stall = 1; exmem_stall = 0.
  - fp_cnt == 0 → RUN; else decrement.
  - dcache_miss in this state: all four stalls, go MEM_WAIT; fp_cnt is held and resumed afterwards.
  - ex_mispredict and lu are ignored (EX frozen).
- MEM_WAIT:
  - All four stalls = 1.
  - dcache_ready → RUN next cycle. Stalls still asserted in the dcache_ready cycle.
  - If fp_cnt != 0, return to FP_BUSY instead of RUN.
- Flush and stall on the same register never coexist: flush wins only in RUN priority 2, and stalls are 0 there.

## Timing
- Reset (rst low, async): state = RUN, fp_cnt = 0, counters = 0. All outputs 0 once inputs are 0.
- Load-use: exactly 1 bubble cycle.
- Mispredict: 0-cycle response; flush is asserted in the same cycle as ex_mispredict.
- FP op: front end held FP_LAT-1 cycles after the ex_fp_start cycle, FP_LAT total.
- Cache miss: stalled from the miss cycle through the dcache_ready cycle inclusive.
- rst asserted mid-FP_BUSY or mid-MEM_WAIT: immediate return to RUN, counter cleared, no residual stall.
- dcache_miss and dcache_ready high in the same RUN cycle: treated as a miss.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - perf_stall_cnt increments on each cycle with pc_stall = 1.
  - perf_flush_cnt increments on each cycle with idex_flush = 1.
  - Both saturate at all-ones.
- Undefined: counter ports and registers are absent; behaviour is otherwise identical.

## Test plan
- Load then dependent add (ex_MemRd=1, ex_rd=5, id_rs1=5, id_use_rs1=1) → one cycle of pc_stall=ifid_stall=idex_flush=1, then all 0. Same case with ex_rd=0 → no stall.
- ex_mispredict=1 with lu also true → ifid_flush=idex_flush=1, pc_stall=0.
- FP_LAT=4, ex_fp_start pulse → pc_stall high for exactly 4 consecutive cycles; busy high for 3.
- dcache_miss in FP_BUSY with fp_cnt=1, dcache_ready 5 cycles later → all stalls for 6 cycles, then 2 more FP_BUSY cycles, then RUN.
- rst low during MEM_WAIT → outputs 0 asynchronously; after release, state RUN.
- With HAZ_PERF_CNT_EN: the mispredict and FP scenarios back-to-back → perf_flush_cnt=1, perf_stall_cnt=4.
